// File: rtl/uart_pkg.sv
// Shared UART constants used by both the transmitter and the 18x receiver:
// bit timing, frame width and the FSM state encodings.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 18;
    localparam int UART_DATA_BITS  = 8;
    localparam int TIMER_W         = 5;
    localparam int BIT_IDX_W       = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] ST_DATA  = 2'b10;
    localparam logic [1:0] ST_STOP  = 2'b11;

    function automatic logic state_is_busy(input logic [1:0] st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..OVERSAMPLE-1 while enabled and pulses bit_end
// in the last cycle of each bit period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(OVERSAMPLE - 1);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    assign bit_end = enable && (count_q == LAST_COUNT);

    // Next count: clear wins, then wrap at the bit end, else advance when enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (bit_end) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + TIMER_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Double-buffered 8N1 UART transmitter: a one-entry holding register feeds a
// shift register, allowing back-to-back frames with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       TX_out
);

    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    logic [1:0]           state_q, state_d;
    logic [7:0]           hold_q, hold_d;
    logic [7:0]           shift_q, shift_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 tx_q, tx_d;

    logic       load_acc_s;
    logic       next_full_s;
    logic [7:0] next_byte_s;
    logic       timer_clr_s;
    logic       timer_en_s;
    logic       bit_end_s;

    // A load landing on the STOP bit end counts as a full holding register.
    assign load_acc_s  = tx_load && ready_q;
    assign next_full_s = load_acc_s || !ready_q;
    assign next_byte_s = ready_q ? tx_data : hold_q;
    assign timer_en_s  = state_is_busy(state_q);

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clr_s),
        .enable  (timer_en_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencing, holding-register handshake and next line level.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        tx_d        = tx_q;
        timer_clr_s = 1'b0;
        if (load_acc_s) begin
            hold_d  = tx_data;
            ready_d = 1'b0;
        end else begin
            hold_d  = hold_q;
            ready_d = ready_q;
        end

        case (state_q)
            ST_IDLE: begin
                timer_clr_s = 1'b1;
                bit_idx_d   = '0;
                if (!ready_q) begin
                    shift_d = hold_q;
                    ready_d = 1'b1;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = ST_STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                        tx_d      = shift_q[1];
                    end
                end else begin
                    tx_d = shift_q[0];
                end
            end
            ST_STOP: begin
                if (bit_end_s && next_full_s) begin
                    shift_d = next_byte_s;
                    ready_d = 1'b1;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else if (bit_end_s) begin
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                bit_idx_d   = '0;
                timer_clr_s = 1'b1;
                tx_d        = 1'b1;
            end
        endcase

        busy_d = state_is_busy(state_d);
    end

    // State and datapath registers; reset abandons any frame and held byte.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            hold_q    <= 8'h00;
            shift_q   <= 8'h00;
            bit_idx_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            tx_q      <= tx_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign TX_out   = tx_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 18, meaning clk cycles per bit period; it matches the 18x receive clock.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame.
REQ-003 SHALL have port clk  input  1  single clock, 18x baud rate, all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port tx_data  input  8  byte to send, sampled only on an accepted load.
REQ-006 SHALL have port tx_load  input  1  load request, accepted in any cycle where tx_ready=1.
REQ-007 SHALL have port tx_ready  output  1  holding register empty; a load is accepted this cycle.
REQ-008 SHALL have port tx_busy  output  1  a frame is on the line (state not IDLE).
REQ-009 SHALL have port TX_out  output  1  serial line, idle high.

Function
REQ-010 SHALL send frames of 1 start bit (0), 8 data bits LSB first, then 1 stop bit (1), with no parity.
REQ-011 SHALL hold every bit on TX_out for exactly OVERSAMPLE clk cycles, so a frame lasts 10*OVERSAMPLE = 180 cycles.
REQ-012 SHALL use a one-entry holding register plus a shift register (double buffered).
REQ-013 SHALL, on tx_load=1 with tx_ready=1, capture tx_data into the holding register and drive tx_ready=0 from the next cycle.
REQ-014 SHALL ignore tx_load when tx_ready=0; the held byte stays unchanged and no error is flagged.
REQ-015 SHALL implement the state machine IDLE -> START -> DATA -> STOP -> (IDLE or START).
REQ-016 SHALL, in IDLE with the holding register full, move the byte into the shifter, set tx_ready=1, and enter START on the next cycle.
REQ-017 SHALL drive TX_out low in the first START cycle, which is cycle N+2 after a load accepted in cycle N while idle.
REQ-018 SHALL keep a 5-bit bit-timer that counts 0..OVERSAMPLE-1; a bit ends at count OVERSAMPLE-1 (17), and the timer then returns to 0.
REQ-019 SHALL, in DATA, shift the shifter right at each bit end and track the bit index with a 4-bit counter (0..7); after the bit-7 end it enters STOP.
REQ-020 SHALL, at the STOP bit end with the holding register full, reload the shifter and go directly to START, giving back-to-back frames with zero idle cycles.
REQ-021 SHALL, at the STOP bit end with the holding register empty, enter IDLE.
REQ-022 SHALL handle a tx_load accepted in the same cycle as a STOP bit end as full, so the next frame follows back-to-back.
REQ-023 SHALL drive tx_busy=1 in START, DATA and STOP, and 0 in IDLE.
REQ-024 SHALL drive TX_out from a register, giving glitch-free output.
REQ-025 SHALL, on an illegal state encoding, return to IDLE with TX_out=1 and its counters cleared.

Reset
REQ-026 SHALL, on a clk edge with reset_n=0, set state=IDLE, TX_out=1, tx_ready=1, tx_busy=0, clear the counters, and clear the holding and shift registers.
REQ-027 SHALL, if reset is asserted mid-frame, abandon the frame and discard any pending held byte; TX_out=1 from the first reset edge.
REQ-028 SHALL take no action on reset_n while there is no clk edge, because reset is fully synchronous.

Structure
REQ-029 SHALL take OVERSAMPLE, DATA_BITS and the state encodings (IDLE=00, START=01, DATA=10, STOP=11) from a shared package, uart_pkg, which the receiver also uses.
REQ-030 SHALL instantiate one sub-module, uart_bit_timer: a count 0..OVERSAMPLE-1 with clear and enable inputs and a bit_end pulse output.
REQ-031 SHALL fit within 120-400 lines of RTL across the top and the sub-module.

Verification
REQ-032 SHALL cover single byte: load 0x55 from idle -> TX_out low at N+2 for 18 cycles, then bits 1,0,1,0,1,0,1,0 at 18 cycles each, stop high, tx_busy low after 180 cycles.
REQ-033 SHALL cover back-to-back: load 0xA5, then 0x3C while the first is shifting -> the two frames are contiguous, with 0 idle cycles between the stop and the next start, and tx_ready rises at the frame boundary.
REQ-034 SHALL cover overrun: a third load of 0xFF while tx_ready=0 -> it is ignored, and only 0xA5 and 0x3C appear on the line.
REQ-035 SHALL cover reset mid-frame: reset_n=0 during the bit-4 period -> TX_out=1, tx_ready=1 and tx_busy=0 after the edge, and no further transitions occur.
REQ-036 SHALL cover loopback: TX_out connected to the 18x receiver, sending 0x00, 0xFF and 0x81 -> the receiver load pulse fires with data matching each byte and error=0.
REQ-037 SHALL cover boundary load: tx_load in the exact STOP bit-end cycle -> the next START begins on the following cycle.
